// File: rtl/float_stream_alu_pkg.sv
// Shared definitions for the float_stream_alu command processor:
// opcodes, command field positions, FSM encoding and format helpers.
package float_stream_alu_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_MUL   = 4'd4;
    localparam logic [3:0] OP_RECIP = 4'd5;
    localparam logic [3:0] OP_ITOF  = 4'd6;
    localparam logic [3:0] OP_FTOI  = 4'd7;
    localparam logic [3:0] OP_READ  = 4'd8;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 28;
    localparam int IDX_MSB    = 27;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        EMIT = 2'd2
    } state_t;

    function automatic int float_size(input int exp_bits, input int man_bits);
        return 1 + exp_bits + man_bits;
    endfunction

endpackage

// File: rtl/float_stream_alu_op_pipe.sv
// Arithmetic cores (add/sub, mul, reciprocal, int<->float) behind one
// shared delay line so every operation completes after OP_LATENCY edges.
module float_op_pipe
    import float_stream_alu_pkg::*;
#(
    parameter int MANTISSA_SIZE = 10,
    parameter int EXPONENT_SIZE = 8,
    parameter int INT_SIZE      = 16,
    parameter int OP_LATENCY    = 4,
    localparam int FS = float_size(EXPONENT_SIZE, MANTISSA_SIZE)
) (
    input  logic          clk,
    input  logic [3:0]    op,
    input  logic [FS-1:0] a,
    input  logic [FS-1:0] b,
    output logic [FS-1:0] result
);

    localparam int M    = MANTISSA_SIZE;
    localparam int E    = EXPONENT_SIZE;
    localparam int BIAS = (1 << (E - 1)) - 1;
    localparam int EMAX = (1 << E) - 1;
    localparam int SW   = 2 * M + 3;
    localparam int QW   = 2 * M + 2;
    localparam int IW   = INT_SIZE + M;

    logic [FS-1:0] core;

    // Denormals are flushed: a zero exponent yields a zero significand.
    function automatic logic [M:0] man(input logic [FS-1:0] x);
        return (x[FS-2:M] != '0) ? {1'b1, x[M-1:0]} : '0;
    endfunction

    function automatic int expo(input logic [FS-1:0] x);
        return int'(x[FS-2:M]);
    endfunction

    // Underflow flushes to zero, overflow becomes infinity.
    function automatic logic [FS-1:0] pack(input logic s, input int ex,
                                           input logic [M-1:0] mt);
        if (ex <= 0) return '0;
        if (ex >= EMAX) return {s, {E{1'b1}}, {M{1'b0}}};
        return {s, E'(ex), mt};
    endfunction

    // Truncating add; the larger magnitude operand sets sign and exponent.
    function automatic logic [FS-1:0] f_add(input logic [FS-1:0] x,
                                            input logic [FS-1:0] y);
        logic [FS-1:0] p, q;
        logic [SW-1:0] mp, mq, sum, nrm;
        int d, lz;
        if (x[FS-2:0] >= y[FS-2:0]) begin
            p = x;
            q = y;
        end else begin
            p = y;
            q = x;
        end
        mp = SW'(man(p)) << (M + 1);
        mq = SW'(man(q)) << (M + 1);
        d = expo(p) - expo(q);
        mq = (d >= SW) ? '0 : (mq >> d);
        sum = (p[FS-1] == q[FS-1]) ? (mp + mq) : (mp - mq);
        lz = -1;
        for (int i = 0; i < SW; i++) if (sum[i]) lz = i;
        if (lz < 0) return '0;
        nrm = sum << (SW - 1 - lz);
        return pack(p[FS-1], expo(p) + lz - (2 * M + 1), nrm[SW-2 -: M]);
    endfunction

    function automatic logic [FS-1:0] f_mul(input logic [FS-1:0] x,
                                            input logic [FS-1:0] y);
        logic [QW-1:0] pr;
        logic s;
        int ex;
        s = x[FS-1] ^ y[FS-1];
        pr = QW'(man(x)) * QW'(man(y));
        if (pr == '0) return '0;
        ex = expo(x) + expo(y) - BIAS;
        if (pr[QW-1]) return pack(s, ex + 1, pr[2*M -: M]);
        return pack(s, ex, pr[2*M-1 -: M]);
    endfunction

    // q holds 2/significand, so it lies in (1,2] scaled by 2^M.
    function automatic logic [FS-1:0] f_rcp(input logic [FS-1:0] x);
        logic [QW-1:0] q;
        if (x[FS-2:M] == '0) return {x[FS-1], {E{1'b1}}, {M{1'b0}}};
        q = (QW'(1) << (2 * M + 1)) / QW'(man(x));
        if (q[M+1]) return pack(x[FS-1], 2 * BIAS - expo(x), '0);
        return pack(x[FS-1], 2 * BIAS - expo(x) - 1, q[M-1:0]);
    endfunction

    function automatic logic [FS-1:0] f_itof(input logic [INT_SIZE-1:0] v);
        logic [INT_SIZE-1:0] mag;
        logic [IW-1:0] sh;
        int lz;
        mag = v[INT_SIZE-1] ? -v : v;
        lz = -1;
        for (int i = 0; i < INT_SIZE; i++) if (mag[i]) lz = i;
        if (lz < 0) return '0;
        sh = {mag, {M{1'b0}}} << (INT_SIZE - 1 - lz);
        return pack(v[INT_SIZE-1], BIAS + lz, sh[IW-2 -: M]);
    endfunction

    // Truncates toward zero and saturates the magnitude on overflow.
    function automatic logic [FS-1:0] f_ftoi(input logic [FS-1:0] x);
        logic [IW-1:0] sh;
        logic [INT_SIZE-1:0] mag;
        int k;
        k = expo(x) - BIAS;
        if (x[FS-2:M] == '0 || k < 0) return '0;
        if (k > INT_SIZE - 2) begin
            mag = {1'b0, {(INT_SIZE-1){1'b1}}};
        end else begin
            sh = IW'(man(x)) << k;
            mag = sh[M +: INT_SIZE];
        end
        mag = x[FS-1] ? -mag : mag;
        return FS'(signed'(mag));
    endfunction

    // Select the core output for the latched opcode.
    always_comb begin
        core = '0;
        case (op)
            OP_ADD:   core = f_add(a, b);
            OP_SUB:   core = f_add(a, {~b[FS-1], b[FS-2:0]});
            OP_MUL:   core = f_mul(a, b);
            OP_RECIP: core = f_rcp(b);
            OP_ITOF:  core = f_itof(b[INT_SIZE-1:0]);
            OP_FTOI:  core = f_ftoi(b);
            default:  core = '0;
        endcase
    end

    generate
        if (OP_LATENCY == 1) begin : g_comb
            assign result = core;
        end else begin : g_dly
            logic [FS-1:0] dly [OP_LATENCY-1];
            // Pad the core result out to the common latency.
            always_ff @(posedge clk) begin
                dly[0] <= core;
                for (int i = 1; i < OP_LATENCY - 1; i++) dly[i] <= dly[i-1];
            end
            assign result = dly[OP_LATENCY-2];
        end
    endgenerate

endmodule

// File: rtl/float_stream_alu.sv
// AXI-stream command processor: accumulator bank, command FSM and
// READ response channel around float_op_pipe.
module float_stream_alu
    import float_stream_alu_pkg::*;
#(
    parameter int MANTISSA_SIZE = 10,
    parameter int EXPONENT_SIZE = 8,
    parameter int INT_SIZE      = 16,
    parameter int NUM_ACC       = 4,
    parameter int OP_LATENCY    = 4,
    localparam int FLOAT_SIZE = float_size(EXPONENT_SIZE, MANTISSA_SIZE),
    localparam int ACC_IDX_W  = $clog2(NUM_ACC)
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [31:0]           s_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [31:0]           m_axis_tdata,
    output logic [FLOAT_SIZE-1:0] acc_mirror,
    output logic                  err_sticky
);

    localparam int CW = (OP_LATENCY > 1) ? $clog2(OP_LATENCY) : 1;

    state_t                state, state_nx;
    logic [FLOAT_SIZE-1:0] acc [NUM_ACC];
    logic [3:0]            op_q;
    logic [ACC_IDX_W-1:0]  idx_q;
    logic [FLOAT_SIZE-1:0] a_q, b_q, result;
    logic [CW-1:0]         cnt;

    logic [3:0]            cmd_op;
    logic [ACC_IDX_W-1:0]  cmd_idx;
    logic [FLOAT_SIZE-1:0] cmd_val;
    logic                  take, is_arith, is_ill;
    logic                  unused;

    assign cmd_op   = s_axis_tdata[OPCODE_MSB:OPCODE_LSB];
    assign cmd_idx  = s_axis_tdata[IDX_MSB -: ACC_IDX_W];
    assign cmd_val  = s_axis_tdata[FLOAT_SIZE-1:0];
    assign unused   = ^s_axis_tdata;
    assign take     = s_axis_tvalid && s_axis_tready;
    assign is_arith = (cmd_op >= OP_ADD) && (cmd_op <= OP_FTOI);
    assign is_ill   = cmd_op > OP_READ;

    assign s_axis_tready = (state == IDLE) && !reset;

    float_op_pipe #(
        .MANTISSA_SIZE (MANTISSA_SIZE),
        .EXPONENT_SIZE (EXPONENT_SIZE),
        .INT_SIZE      (INT_SIZE),
        .OP_LATENCY    (OP_LATENCY)
    ) u_pipe (
        .clk    (aclk),
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (result)
    );

    // State register.
    always_ff @(posedge aclk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state: arithmetic runs in EXEC, READ waits in EMIT.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (take && is_arith)            state_nx = EXEC;
                else if (take && cmd_op == OP_READ) state_nx = EMIT;
            end
            EXEC:    if (cnt == '0) state_nx = IDLE;
            EMIT:    if (m_axis_tready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Accumulators, operand latches, latency counter and response regs.
    always_ff @(posedge aclk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
            acc_mirror    <= '0;
            err_sticky    <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            cnt           <= '0;
            op_q          <= OP_NOP;
            idx_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
        end else begin
            unique case (state)
                IDLE: if (take) begin
                    if (cmd_op == OP_LOAD) begin
                        acc[cmd_idx] <= cmd_val;
                        acc_mirror   <= cmd_val;
                    end
                    if (is_ill) err_sticky <= 1'b1;
                    if (is_arith) begin
                        op_q  <= cmd_op;
                        idx_q <= cmd_idx;
                        a_q   <= acc[cmd_idx];
                        b_q   <= cmd_val;
                        cnt   <= CW'(OP_LATENCY - 1);
                    end
                    if (cmd_op == OP_READ) begin
                        m_axis_tdata  <= 32'(acc[cmd_idx]);
                        m_axis_tlast  <= s_axis_tlast;
                        m_axis_tvalid <= 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        acc[idx_q] <= result;
                        acc_mirror <= result;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                EMIT:    if (m_axis_tready) m_axis_tvalid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_stream_alu.sv
// Directed bench for float_stream_alu: READ responses are checked
// against a queue of expected beats filled as commands are issued.
module tb_float_stream_alu;

    localparam int LAT = 4;
    localparam int FS  = 19;

    logic          aclk = 1'b0;
    logic          reset;
    logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [31:0]   s_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [31:0]   m_axis_tdata;
    logic [FS-1:0] acc_mirror;
    logic          err_sticky;

    int vectors = 0;
    int miscompares = 0;
    logic [32:0] sb [$];

    always #5 aclk = ~aclk;

    float_stream_alu dut (
        .aclk          (aclk),
        .reset         (reset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .acc_mirror    (acc_mirror),
        .err_sticky    (err_sticky)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command; returns just after the accepting edge.
    task automatic send(input logic [3:0] op, input int idx,
                        input logic [31:0] val, input logic last);
        int n;
        @(negedge aclk);
        s_axis_tdata  = {op, 28'd0} | (32'(idx) << 26) | val;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        n = 0;
        while (!s_axis_tready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("cmd_accept", s_axis_tready, 1);
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    // Arithmetic op; also measures how long tready stays low.
    task automatic arith(input logic [3:0] op, input int idx,
                         input logic [31:0] val, input string tag);
        int low;
        send(op, idx, val, 1'b0);
        low = 0;
        @(negedge aclk);
        while (!s_axis_tready && low < 50) begin
            low++;
            @(negedge aclk);
        end
        check(tag, low, LAT);
    endtask

    // READ with m_axis_tready high: beat valid right after acceptance.
    task automatic read(input int idx, input logic [FS-1:0] exp,
                        input string tag);
        logic [32:0] e;
        sb.push_back({1'b0, 32'(exp)});
        send(4'd8, idx, 32'd0, 1'b0);
        check({tag, "_valid"}, m_axis_tvalid, 1);
        e = sb.pop_front();
        check(tag, {m_axis_tlast, m_axis_tdata}, e);
        @(posedge aclk);
        #1;
        check({tag, "_drop"}, m_axis_tvalid, 0);
    endtask

    initial begin
        logic [32:0] e;
        reset         = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_tready", s_axis_tready, 0);
        reset = 1'b0;
        #1;
        check("rst_out", {s_axis_tready, m_axis_tvalid, m_axis_tlast,
                          m_axis_tdata, err_sticky},
              {1'b1, 1'b0, 1'b0, 32'd0, 1'b0});
        check("rst_mirror", acc_mirror, 0);

        send(4'd1, 0, 32'h1FC00, 1'b0);
        check("load_tready", s_axis_tready, 1);
        check("load_mirror", acc_mirror, 19'h1FC00);
        read(0, 19'h1FC00, "rd_acc0");

        send(4'd1, 1, 32'h20000, 1'b0);
        arith(4'd2, 1, 32'h1FC00, "add_busy");
        check("add_mirror", acc_mirror, 19'h20200);
        read(1, 19'h20200, "rd_add");

        arith(4'd4, 1, 32'h1F800, "mul_busy");
        read(1, 19'h1FE00, "rd_mul");
        arith(4'd3, 1, 32'h20000, "sub_busy");
        read(1, 19'h5F800, "rd_sub");
        arith(4'd5, 2, 32'h20000, "rcp_busy");
        read(2, 19'h1F800, "rd_rcp");

        arith(4'd6, 3, 32'h0005, "itof_busy");
        read(3, 19'h20500, "rd_itof");
        arith(4'd7, 3, 32'h20500, "ftoi_busy");
        read(3, 19'h00005, "rd_ftoi");
        arith(4'd7, 3, 32'h20400, "ftoi4_busy");
        read(3, 19'h00004, "rd_ftoi4");
        arith(4'd6, 2, 32'hFFFD, "itofn_busy");
        read(2, 19'h60200, "rd_itofn");
        arith(4'd7, 2, 32'h60200, "ftoin_busy");
        read(2, 19'h7FFFD, "rd_ftoin");

        // Junk in the unused middle bits must not reach the accumulator.
        send(4'd1, 2, 32'h03F8_0000 | 32'h20000, 1'b0);
        read(2, 19'h20000, "rd_junk");

        // Back-pressured READ with tlast set.
        m_axis_tready = 1'b0;
        sb.push_back({1'b1, 32'h0001FC00});
        send(4'd8, 0, 32'd0, 1'b1);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            check("stall_beat", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                  {1'b1, e});
            check("stall_tready", s_axis_tready, 0);
            @(posedge aclk);
            #1;
        end
        @(negedge aclk);
        m_axis_tready = 1'b1;
        @(posedge aclk);
        #1;
        check("stall_done", {m_axis_tvalid, s_axis_tready}, 2'b01);

        send(4'hF, 0, 32'h12345, 1'b0);
        check("ill_err", err_sticky, 1);
        check("ill_mirror", acc_mirror, 19'h20000);
        read(0, 19'h1FC00, "rd_ill");
        check("ill_sticky", err_sticky, 1);

        // Reset two cycles into an ADD: result must be discarded.
        send(4'd2, 0, 32'h1FC00, 1'b0);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        reset = 1'b1;
        @(negedge aclk);
        reset = 1'b0;
        #1;
        check("rx_tready", s_axis_tready, 1);
        check("rx_err", err_sticky, 0);
        repeat (LAT + 2) @(posedge aclk);
        #1;
        check("rx_mirror", acc_mirror, 0);
        read(0, 19'h0, "rd_rx");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
